// File: rtl/result_pipeline.sv
// MEM and WB stages of the integer pipeline: EX/MEM and MEM/WB registers,
// a data-memory handshake with a timeout abort, and forwarding outputs.
module result_pipeline #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [4:0]  rd_ex,
    input  logic        register_write_ex,
    input  logic        mem_read_ex,
    input  logic        mem_write_ex,
    input  logic [31:0] alu_result_ex,
    input  logic [31:0] rs2_data_ex,
    input  logic        flush_ex,
    output logic        pipe_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [4:0]  rd_mem,
    output logic        register_write_mem,
    output logic [31:0] fwd_data_mem,
    output logic [4:0]  rd_wb,
    output logic        register_write_wb,
    output logic [31:0] result_wb,
    output logic        dmem_err
);

    typedef enum logic {IDLE, WAIT} state_t;

    // The IDLE cycle that issues the access is itself a wait cycle, so the
    // abort fires once the WAIT counter hits TIMEOUT-1.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [7:0]  wait_cnt, wait_cnt_next;
    logic        err;

    logic        mem_valid, mem_rw, mem_mr, mem_mw;
    logic [4:0]  mem_rd;
    logic [31:0] mem_alu, mem_sd;

    logic        wb_valid, wb_rw;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;

    logic mem_op, is_store, abort;

    assign mem_op   = mem_valid & (mem_mr | mem_mw);
    assign is_store = mem_mw & ~mem_mr;
    assign abort    = mem_op & ~dmem_ready & (state == WAIT) & (wait_cnt == TIMEOUT_LAST);

    assign pipe_stall = mem_op & ~dmem_ready & ~abort;
    assign dmem_req   = mem_op & ~abort;
    assign dmem_we    = dmem_req & is_store;
    assign dmem_addr  = mem_alu;
    assign dmem_wdata = mem_sd;

    // Loads are not forwardable from MEM; writes to x0 never count.
    assign register_write_mem = mem_valid & mem_rw & ~mem_mr & (mem_rd != 5'd0);
    assign rd_mem             = mem_rd;
    assign fwd_data_mem       = mem_alu;

    assign register_write_wb = wb_valid & wb_rw & (wb_rd != 5'd0);
    assign rd_wb             = wb_rd;
    assign result_wb         = wb_result;
    assign dmem_err          = err;

    always_comb begin
        state_next    = state;
        wait_cnt_next = 8'd0;
        case (state)
            IDLE: if (mem_op && !dmem_ready) state_next = WAIT;
            WAIT: begin
                if (!mem_op || dmem_ready || abort) state_next = IDLE;
                else wait_cnt_next = wait_cnt + 8'd1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
            err      <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (abort) err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid <= 1'b0;
            mem_rd    <= 5'd0;
            mem_rw    <= 1'b0;
            mem_mr    <= 1'b0;
            mem_mw    <= 1'b0;
            mem_alu   <= 32'd0;
            mem_sd    <= 32'd0;
        end else if (!pipe_stall) begin
            mem_valid <= ex_valid & ~flush_ex;
            mem_rd    <= rd_ex;
            mem_rw    <= register_write_ex & ex_valid & ~flush_ex;
            mem_mr    <= mem_read_ex;
            mem_mw    <= mem_write_ex;
            mem_alu   <= alu_result_ex;
            mem_sd    <= rs2_data_ex;
        end
    end

    // A stalled or aborted access leaves a bubble behind in WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid  <= 1'b0;
            wb_rd     <= 5'd0;
            wb_rw     <= 1'b0;
            wb_result <= 32'd0;
        end else if (pipe_stall || abort || !mem_valid) begin
            wb_valid  <= 1'b0;
            wb_rd     <= 5'd0;
            wb_rw     <= 1'b0;
            wb_result <= 32'd0;
        end else begin
            wb_valid  <= 1'b1;
            wb_rd     <= mem_rd;
            wb_rw     <= mem_rw & ~is_store;
            wb_result <= mem_mr ? dmem_rdata : mem_alu;
        end
    end

endmodule

// File: tb/tb_result_pipeline.sv
// Directed bench for result_pipeline: a transaction-level model predicts every
// output each cycle, and literal expectations pin the key scenarios.
module tb_result_pipeline;

    localparam int TO = 4;

    logic        clk, rst_n;
    logic        ex_valid, register_write_ex, mem_read_ex, mem_write_ex, flush_ex;
    logic [4:0]  rd_ex;
    logic [31:0] alu_result_ex, rs2_data_ex;
    logic        pipe_stall, dmem_req, dmem_we, dmem_ready, dmem_err;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [4:0]  rd_mem, rd_wb;
    logic        register_write_mem, register_write_wb;
    logic [31:0] fwd_data_mem, result_wb;

    int total = 0;
    int bad   = 0;
    bit chk_on = 0;

    result_pipeline #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .rd_ex(rd_ex), .register_write_ex(register_write_ex),
        .mem_read_ex(mem_read_ex), .mem_write_ex(mem_write_ex),
        .alu_result_ex(alu_result_ex), .rs2_data_ex(rs2_data_ex), .flush_ex(flush_ex),
        .pipe_stall(pipe_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .rd_mem(rd_mem), .register_write_mem(register_write_mem), .fwd_data_mem(fwd_data_mem),
        .rd_wb(rd_wb), .register_write_wb(register_write_wb), .result_wb(result_wb),
        .dmem_err(dmem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the instruction sitting in MEM, what WB currently holds, and how
    // many cycles the MEM instruction has already been stalled.
    typedef struct {
        bit          v;
        bit [4:0]    rd;
        bit          rw, mr, mw;
        bit [31:0]   alu, sd;
    } mem_t;
    typedef struct {
        bit          v;
        bit [4:0]    rd;
        bit          rw;
        bit [31:0]   res;
    } wb_t;

    mem_t m = '{default: 0};
    wb_t  w = '{default: 0};
    int   waited = 0;
    bit   m_err = 0;

    bit exp_memop, exp_abort, exp_stall, exp_req, exp_we, exp_rwm, exp_rww;

    always_comb begin
        exp_memop = m.v && (m.mr || m.mw);
        exp_abort = exp_memop && !dmem_ready && (waited >= TO);
        exp_stall = exp_memop && !dmem_ready && !exp_abort;
        exp_req   = exp_memop && !exp_abort;
        exp_we    = exp_req && m.mw && !m.mr;
        exp_rwm   = m.v && m.rw && !m.mr && (m.rd != 5'd0);
        exp_rww   = w.v && w.rw && (w.rd != 5'd0);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m      <= '{default: 0};
            w      <= '{default: 0};
            waited <= 0;
            m_err  <= 1'b0;
        end else if (exp_stall) begin
            w      <= '{default: 0};
            waited <= waited + 1;
        end else begin
            if (m.v && !exp_abort)
                w <= '{1'b1, m.rd, m.rw && !(m.mw && !m.mr), m.mr ? dmem_rdata : m.alu};
            else
                w <= '{default: 0};
            if (exp_abort) m_err <= 1'b1;
            m <= '{ex_valid && !flush_ex, rd_ex, register_write_ex && !flush_ex,
                   mem_read_ex, mem_write_ex, alu_result_ex, rs2_data_ex};
            waited <= 0;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check_output(name, 32'(act), 32'(exp));
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check_bit("m.pipe_stall", pipe_stall, exp_stall);
            check_bit("m.dmem_req", dmem_req, exp_req);
            if (exp_req) begin
                check_bit("m.dmem_we", dmem_we, exp_we);
                check_output("m.dmem_addr", dmem_addr, m.alu);
                if (exp_we) check_output("m.dmem_wdata", dmem_wdata, m.sd);
            end
            check_bit("m.reg_write_mem", register_write_mem, exp_rwm);
            if (exp_rwm) begin
                check_output("m.rd_mem", 32'(rd_mem), 32'(m.rd));
                check_output("m.fwd_data_mem", fwd_data_mem, m.alu);
            end
            check_bit("m.reg_write_wb", register_write_wb, exp_rww);
            if (exp_rww) begin
                check_output("m.rd_wb", 32'(rd_wb), 32'(w.rd));
                check_output("m.result_wb", result_wb, w.res);
            end
            check_bit("m.dmem_err", dmem_err, m_err);
        end
    end

    task automatic apply_stimulus(input bit v, input bit [4:0] rd, input bit rw, input bit mr,
                                  input bit mw, input logic [31:0] alu, input logic [31:0] sd,
                                  input bit fl);
        ex_valid          = v;
        rd_ex             = rd;
        register_write_ex = rw;
        mem_read_ex       = mr;
        mem_write_ex      = mw;
        alu_result_ex     = alu;
        rs2_data_ex       = sd;
        flush_ex          = fl;
    endtask

    task automatic apply_idle();
        apply_stimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        apply_idle();
        #1 chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_bit("rst.pipe_stall", pipe_stall, 1'b0);
        check_bit("rst.dmem_req", dmem_req, 1'b0);
        check_bit("rst.reg_write_mem", register_write_mem, 1'b0);
        check_bit("rst.reg_write_wb", register_write_wb, 1'b0);
        check_output("rst.result_wb", result_wb, 32'h0);
        check_bit("rst.dmem_err", dmem_err, 1'b0);
        rst_n = 1'b1;
        cyc();

        // ALU op reaches MEM then WB
        apply_stimulus(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 1'b0);
        cyc();
        apply_idle();
        @(negedge clk);
        check_output("alu.rd_mem", 32'(rd_mem), 32'd5);
        check_bit("alu.reg_write_mem", register_write_mem, 1'b1);
        check_output("alu.fwd_data_mem", fwd_data_mem, 32'h1234);
        cyc();
        @(negedge clk);
        check_output("alu.rd_wb", 32'(rd_wb), 32'd5);
        check_bit("alu.reg_write_wb", register_write_wb, 1'b1);
        check_output("alu.result_wb", result_wb, 32'h1234);

        // Load with three not-ready cycles
        apply_stimulus(1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0);
        cyc();
        apply_idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_bit("ld.pipe_stall", pipe_stall, 1'b1);
            check_bit("ld.reg_write_mem", register_write_mem, 1'b0);
            check_bit("ld.wb_bubble", register_write_wb, 1'b0);
            check_output("ld.dmem_addr", dmem_addr, 32'h100);
            cyc();
        end
        dmem_ready = 1'b1;
        dmem_rdata = 32'hCAFE;
        @(negedge clk);
        check_bit("ld.done_stall", pipe_stall, 1'b0);
        cyc();
        dmem_ready = 1'b0;
        @(negedge clk);
        check_bit("ld.reg_write_wb", register_write_wb, 1'b1);
        check_output("ld.rd_wb", 32'(rd_wb), 32'd7);
        check_output("ld.result_wb", result_wb, 32'hCAFE);

        // Store accepted immediately
        apply_stimulus(1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 32'h40, 32'hAA, 1'b0);
        cyc();
        apply_idle();
        dmem_ready = 1'b1;
        @(negedge clk);
        check_bit("st.dmem_we", dmem_we, 1'b1);
        check_bit("st.pipe_stall", pipe_stall, 1'b0);
        check_output("st.dmem_addr", dmem_addr, 32'h40);
        check_output("st.dmem_wdata", dmem_wdata, 32'hAA);
        cyc();
        dmem_ready = 1'b0;
        @(negedge clk);
        check_bit("st.reg_write_wb", register_write_wb, 1'b0);

        // Flushed op, then a write to x0
        apply_stimulus(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 32'h33, 32'h0, 1'b1);
        cyc();
        apply_stimulus(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 1'b0);
        @(negedge clk);
        check_bit("fl.reg_write_mem", register_write_mem, 1'b0);
        cyc();
        apply_idle();
        @(negedge clk);
        check_bit("fl.reg_write_wb", register_write_wb, 1'b0);
        check_bit("x0.reg_write_mem", register_write_mem, 1'b0);
        cyc();
        @(negedge clk);
        check_bit("x0.reg_write_wb", register_write_wb, 1'b0);

        // Back-to-back mix of ALU ops and zero-wait loads
        dmem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dmem_rdata = 32'hD000 + 32'(i);
            if (i % 2 == 1)
                apply_stimulus(1'b1, 5'(i + 10), 1'b1, 1'b1, 1'b0, 32'h300 + 32'(4 * i), 32'h0, 1'b0);
            else
                apply_stimulus(1'b1, 5'(i + 10), 1'b1, 1'b0, 1'b0, 32'h1000 * 32'(i) + 32'h5, 32'h0, 1'b0);
            cyc();
        end
        apply_idle();
        cyc();
        cyc();
        dmem_ready = 1'b0;

        // Load that never completes: timeout abort, next op accepted
        apply_stimulus(1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 1'b0);
        cyc();
        apply_stimulus(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 1'b0);
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            check_bit("to.pipe_stall", pipe_stall, 1'b1);
            cyc();
        end
        @(negedge clk);
        check_bit("to.abort_stall", pipe_stall, 1'b0);
        check_bit("to.abort_req", dmem_req, 1'b0);
        check_bit("to.err_before", dmem_err, 1'b0);
        cyc();
        apply_idle();
        @(negedge clk);
        check_bit("to.dmem_err", dmem_err, 1'b1);
        check_bit("to.wb_bubble", register_write_wb, 1'b0);
        check_output("to.rd_mem", 32'(rd_mem), 32'd4);
        check_bit("to.reg_write_mem", register_write_mem, 1'b1);
        cyc();
        @(negedge clk);
        check_output("to.rd_wb", 32'(rd_wb), 32'd4);
        check_output("to.result_wb", result_wb, 32'h44);
        repeat (3) cyc();
        @(negedge clk);
        check_bit("to.err_sticky", dmem_err, 1'b1);

        // Reset while waiting on memory abandons the access
        apply_stimulus(1'b1, 5'd12, 1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 1'b0);
        cyc();
        apply_idle();
        cyc();
        #2 rst_n = 1'b0;
        #1;
        check_bit("rw.pipe_stall", pipe_stall, 1'b0);
        check_bit("rw.dmem_req", dmem_req, 1'b0);
        check_bit("rw.dmem_err", dmem_err, 1'b0);
        check_bit("rw.reg_write_wb", register_write_wb, 1'b0);
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        check_bit("rw.post_stall", pipe_stall, 1'b0);
        check_bit("rw.post_req", dmem_req, 1'b0);
        cyc();
        @(negedge clk);
        check_bit("rw.post_wb", register_write_wb, 1'b0);
        cyc();

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/result_pipeline.md
RESULT_PIPELINE -- requirements
Module: result_pipeline

Interface
REQ-001 SHALL have port clk, in, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, in, 1, asynchronous active-low reset.
REQ-003 SHALL have EX-side inputs: ex_valid 1; rd_ex 5; register_write_ex 1; mem_read_ex 1; mem_write_ex 1; alu_result_ex 32; rs2_data_ex 32 (store data).
REQ-004 SHALL have input flush_ex, 1, squashes the EX instruction presented this cycle.
REQ-005 SHALL have output pipe_stall, 1, high when EX/MEM cannot accept; upstream holds its EX inputs.
REQ-006 SHALL have data-memory ports: dmem_req out 1; dmem_we out 1; dmem_addr out 32; dmem_wdata out 32; dmem_ready in 1; dmem_rdata in 32.
REQ-007 SHALL have MEM-stage outputs for the forwarding units: rd_mem 5; register_write_mem 1; fwd_data_mem 32.
REQ-008 SHALL have WB-stage outputs: rd_wb 5; register_write_wb 1; result_wb 32.
REQ-009 SHALL have output dmem_err, 1, sticky timeout flag.
REQ-010 SHALL have parameter TIMEOUT, default 255, maximum wait cycles per memory access (8-bit counter).

Function
REQ-011 SHALL hold an EX/MEM register (valid, rd, reg_write, mem_read, mem_write, alu_result, store data) and a MEM/WB register (valid, rd, reg_write, result).
REQ-012 SHALL define MEM entry "mem op" as valid & (mem_read | mem_write); mem_read and mem_write both set is illegal and treated as a load.
REQ-013 SHALL implement FSM {IDLE, WAIT}; reset state IDLE.
REQ-014 SHALL drive dmem_req=1 whenever the MEM entry is a mem op and dmem_err-abort is not occurring, in IDLE or WAIT; dmem_we=mem_write&~mem_read; dmem_addr=alu_result; dmem_wdata=store data; all stable while in WAIT.
REQ-015 SHALL complete an access in the cycle dmem_req=1 and dmem_ready=1; dmem_ready without dmem_req SHALL be ignored.
REQ-016 SHALL, IDLE with mem op and dmem_ready=0, go to WAIT; WAIT with dmem_ready=1 returns to IDLE; IDLE without stall remains IDLE.
REQ-017 SHALL assert pipe_stall = MEM entry is a mem op & ~(dmem_ready) & ~timeout-abort (combinational).
REQ-018 SHALL, when not stalled, load EX/MEM from EX inputs with valid = ex_valid & ~flush_ex; when flush_ex=1 the captured entry has valid=0 and reg_write=0.
REQ-019 SHALL, when stalled, hold EX/MEM unchanged and load MEM/WB with a bubble (valid=0, reg_write=0); flush_ex is ignored while stalled (upstream keeps it asserted until accepted).
REQ-020 SHALL, when not stalled, load MEM/WB from EX/MEM: result = dmem_rdata for loads, alu_result otherwise; stores and bubbles give register_write_wb=0.
REQ-021 SHALL output register_write_mem = valid & reg_write & ~mem_read (loads are not forwardable from MEM), rd_mem = EX/MEM rd, fwd_data_mem = EX/MEM alu_result.
REQ-022 SHALL output register_write_wb = MEM/WB valid & reg_write; rd_wb and result_wb from MEM/WB.
REQ-023 SHALL force register_write_mem and register_write_wb to 0 when respective rd = 0.
REQ-024 SHALL count wait cycles in WAIT; counter clears on entering WAIT and in IDLE.
REQ-025 SHALL, when counter reaches TIMEOUT without dmem_ready, abort: deassert pipe_stall and dmem_req that cycle, set dmem_err=1, pass a bubble to MEM/WB, return to IDLE.
REQ-026 SHALL keep dmem_err set until reset.
REQ-027 Latency: non-memory instruction reaches WB outputs 2 cycles after EX acceptance; memory instruction 2 + wait cycles.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously clear both pipeline registers (valid=0, rd=0, reg_write=0, data=0), FSM=IDLE, counter=0, dmem_err=0.
REQ-029 SHALL drive outputs during reset: pipe_stall=0, dmem_req=0, dmem_we=0, all data/rd outputs 0, register_write_* 0.
REQ-030 SHALL, on reset asserted in WAIT, abandon the access with no WB write; first post-reset cycle is IDLE.

Verification
REQ-031 ALU op rd=5, result 0x1234, reg_write=1 -> cycle+1 rd_mem=5, register_write_mem=1, fwd_data_mem=0x1234; cycle+2 rd_wb=5, result_wb=0x1234.
REQ-032 Load rd=7 addr 0x100, dmem_ready low 3 cycles then high with rdata 0xCAFE -> pipe_stall high 3 cycles, 3 WB bubbles, register_write_mem=0 throughout, then result_wb=0xCAFE rd_wb=7.
REQ-033 Store addr 0x40 data 0xAA, ready same cycle -> dmem_we=1, no stall, register_write_wb=0.
REQ-034 ALU op rd=3 with flush_ex=1 -> register_write_mem=0 next cycle, register_write_wb=0 cycle after; rd=0 with reg_write=1 -> register_write_mem=0.
REQ-035 TIMEOUT=4, load with dmem_ready stuck 0 -> stall 4 cycles, then dmem_err=1, bubble to WB, next EX op accepted; dmem_err stays 1 until rst_n pulse.
